// File: rtl/capp_sequencer.sv
// capp_sequencer -- command sequencer for the content-addressable cell array.
//
// Accepts one command at a time (SEARCH / WRITE / SEARCH_WRITE / READ) and
// walks IDLE -> SETTLE -> CAPTURE -> WRITE -> RESP as the op requires. It
// drives the dual-rail match and write lines, samples the tag and read lines,
// and holds a registered response until it is accepted.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_*    command handshake, op, search key/mask,
//                                write data/mask
//   resp_valid/resp_ready/resp_* response handshake, any flag, lowest tagged
//                                index, read data
//   match_lines, write_lines     dual-rail drive to the array (2 lines/bit)
//   tag_lines, read_lines        per-word tags and wired-OR read data
//
// Optional: `define CAPP_RESP_COUNT_EN adds resp_count, the population count
// of tag_lines taken in CAPTURE. The popcount is single-cycle, so latencies
// are unchanged when the feature is enabled.

// Per-bit dual-rail encoder: one instance per word bit.
module capp_bit_enc (
  input  logic       comparand,
  input  logic       smask,
  input  logic       wdata,
  input  logic       wmask,
  output logic [1:0] match_pair,
  output logic [1:0] write_pair
);
  assign match_pair = {smask & comparand, smask & ~comparand};
  assign write_pair = {wmask & ~wdata, wmask & wdata};
endmodule

module capp_sequencer #(
  parameter int WORD_W        = 32,
  parameter int NUM_WORDS     = 100,
  parameter int SETTLE_CYCLES = 2,
  parameter int WRITE_CYCLES  = 1,
  parameter int IDX_W         = $clog2(NUM_WORDS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [WORD_W-1:0]      cmd_comparand,
  input  logic [WORD_W-1:0]      cmd_smask,
  input  logic [WORD_W-1:0]      cmd_wdata,
  input  logic [WORD_W-1:0]      cmd_wmask,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_any,
  output logic [IDX_W-1:0]       resp_first_idx,
  output logic [WORD_W-1:0]      resp_rdata,
`ifdef CAPP_RESP_COUNT_EN
  output logic [$clog2(NUM_WORDS+1)-1:0] resp_count,
`endif
  output logic [2*WORD_W-1:0]    match_lines,
  output logic [2*WORD_W-1:0]    write_lines,
  input  logic [NUM_WORDS-1:0]   tag_lines,
  input  logic [WORD_W-1:0]      read_lines
);

  localparam logic [1:0] OP_SEARCH = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_SW     = 2'd2;
  localparam logic [1:0] OP_READ   = 2'd3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam int MAXC  = (SETTLE_CYCLES > WRITE_CYCLES) ? SETTLE_CYCLES : WRITE_CYCLES;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int CNT_W = $clog2(NUM_WORDS+1);

  logic [2:0]          state;
  logic [CW-1:0]       cnt;
  logic [1:0]          op_q;
  logic [2*WORD_W-1:0] wenc_q;
  logic [2*WORD_W-1:0] match_nxt, write_nxt;

  genvar j;
  generate
    for (j = 0; j < WORD_W; j++) begin : g_enc
      capp_bit_enc u_enc (
        .comparand  (cmd_comparand[j]),
        .smask      (cmd_smask[j]),
        .wdata      (cmd_wdata[j]),
        .wmask      (cmd_wmask[j]),
        .match_pair (match_nxt[2*j +: 2]),
        .write_pair (write_nxt[2*j +: 2])
      );
    end
  endgenerate

  // Tag reduction: any, lowest set index (last assignment wins), popcount.
  logic             tag_any;
  logic [IDX_W-1:0] first_idx;
  logic [CNT_W-1:0] pop;
  assign tag_any = |tag_lines;
  always_comb begin
    first_idx = '0;
    pop       = '0;
    for (int i = NUM_WORDS-1; i >= 0; i--) begin
      if (tag_lines[i]) first_idx = IDX_W'(i);
      pop = pop + CNT_W'(tag_lines[i]);
    end
  end

  assign cmd_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  // Write drive is gated by state, so reset or leaving WRITE kills it at once.
  assign write_lines = (state == S_WRITE) ? wenc_q : '0;

  logic settle_done, write_done;
  assign settle_done = (cnt == CW'(SETTLE_CYCLES-1));
  assign write_done  = (cnt == CW'(WRITE_CYCLES-1));

`ifndef CAPP_RESP_COUNT_EN
  logic unused_pop;
  assign unused_pop = ^pop;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      op_q           <= OP_SEARCH;
      wenc_q         <= '0;
      match_lines    <= '0;
      resp_any       <= 1'b0;
      resp_first_idx <= '0;
      resp_rdata     <= '0;
`ifdef CAPP_RESP_COUNT_EN
      resp_count     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) begin
          op_q   <= cmd_op;
          wenc_q <= write_nxt;
          cnt    <= '0;
          // WRITE and READ reuse the match lines of the last search.
          if (cmd_op == OP_SEARCH || cmd_op == OP_SW) match_lines <= match_nxt;
          state  <= (cmd_op == OP_WRITE) ? S_WRITE : S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_done) begin
            cnt   <= '0;
            state <= S_CAPTURE;
          end else cnt <= cnt + CW'(1);
        end
        S_CAPTURE: begin
          resp_any       <= tag_any;
          resp_first_idx <= first_idx;
          resp_rdata     <= (op_q == OP_READ) ? read_lines : '0;
`ifdef CAPP_RESP_COUNT_EN
          resp_count     <= pop;
`endif
          cnt   <= '0;
          state <= (op_q == OP_SW) ? S_WRITE : S_RESP;
        end
        S_WRITE: begin
          if (write_done) begin
            // A plain WRITE has no CAPTURE; it reports tags seen while writing.
            if (op_q == OP_WRITE) begin
              resp_any       <= tag_any;
              resp_first_idx <= first_idx;
              resp_rdata     <= '0;
`ifdef CAPP_RESP_COUNT_EN
              resp_count     <= pop;
`endif
            end
            cnt   <= '0;
            state <= S_RESP;
          end else cnt <= cnt + CW'(1);
        end
        S_RESP: if (resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capp_sequencer.sv
module tb_capp_sequencer;
  localparam int WORD_W = 32;
  localparam int NUM_WORDS = 100;
  localparam int IDX_W = 7;
  localparam int CNT_W = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [WORD_W-1:0] cmd_comparand = '0, cmd_smask = '0, cmd_wdata = '0, cmd_wmask = '0;
  logic resp_valid;
  logic resp_ready = 1'b1;
  logic resp_any;
  logic [IDX_W-1:0] resp_first_idx;
  logic [WORD_W-1:0] resp_rdata;
  logic [2*WORD_W-1:0] match_lines, write_lines;
  logic [NUM_WORDS-1:0] tag_lines = '0;
  logic [WORD_W-1:0] read_lines = '0;
`ifdef CAPP_RESP_COUNT_EN
  logic [CNT_W-1:0] resp_count;
`endif

  capp_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_comparand(cmd_comparand), .cmd_smask(cmd_smask),
    .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_any(resp_any),
    .resp_first_idx(resp_first_idx), .resp_rdata(resp_rdata),
`ifdef CAPP_RESP_COUNT_EN
    .resp_count(resp_count),
`endif
    .match_lines(match_lines), .write_lines(write_lines),
    .tag_lines(tag_lines), .read_lines(read_lines)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic             any;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rdata;
    logic [CNT_W-1:0] cnt;
    int               lat;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Cycles with any write line high, and the last nonzero pattern seen.
  int wl_cycles = 0;
  logic [63:0] wl_last = '0;
  always @(negedge clk) if (write_lines != '0) begin
    wl_cycles <= wl_cycles + 1;
    wl_last   <= write_lines;
  end

  // Monitor: pop on first sight of a response, recheck fields at handshake.
  // Latency is counted to the first clock edge at which resp_valid is sampled high.
  bit seen = 0;
  bit have = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) seen = 0;
    else if (resp_valid) begin
      if (!seen) begin
        seen = 1;
        if (sb.size() == 0) begin
          have = 0;
          checks++; fails++;
          $display("FAIL unexpected_resp actual=resp_valid expected=no response");
        end else begin
          have = 1;
          cur = sb.pop_front();
          chk("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
          chk("resp_any", 64'(resp_any), 64'(cur.any));
          chk("resp_first_idx", 64'(resp_first_idx), 64'(cur.idx));
          chk("resp_rdata", 64'(resp_rdata), 64'(cur.rdata));
`ifdef CAPP_RESP_COUNT_EN
          chk("resp_count", 64'(resp_count), 64'(cur.cnt));
`endif
        end
      end
      if (resp_ready) begin
        if (have) begin
          chk("held_any", 64'(resp_any), 64'(cur.any));
          chk("held_idx", 64'(resp_first_idx), 64'(cur.idx));
          chk("held_rdata", 64'(resp_rdata), 64'(cur.rdata));
        end
        seen = 0;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] comp, input logic [31:0] sm,
                       input logic [31:0] wd, input logic [31:0] wm, input bit push, input exp_t e);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_comparand = comp; cmd_smask = sm;
    cmd_wdata = wd; cmd_wmask = wm;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) begin
      checks++; fails++;
      $display("FAIL cmd_ready_timeout actual=0 expected=1");
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (push) begin e.acc = cyc; sb.push_back(e); end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(cmd_ready && !resp_valid) && n < 100) begin @(posedge clk); #1; n++; end
    if (!(cmd_ready && !resp_valid)) begin
      checks++; fails++;
      $display("FAIL done_timeout actual=busy expected=idle");
    end
  endtask

  function automatic exp_t mk(input logic any, input int idx, input logic [31:0] rd,
                              input int cnt, input int lat);
    exp_t e;
    e.any = any; e.idx = IDX_W'(idx); e.rdata = rd; e.cnt = CNT_W'(cnt);
    e.lat = lat; e.acc = 0;
    return e;
  endfunction

  initial begin
    exp_t none;
    int n;
    none = mk(0, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_match", match_lines, 64'd0);
    chk("rst_write", write_lines, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset in the middle of SETTLE.
    issue(2'd0, 32'hFF, 32'hFF, 32'h0, 32'h0, 0, none);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("midrst_match", match_lines, 64'd0);
    chk("midrst_write", write_lines, 64'd0);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // SEARCH tagging words 7 and 42.
    tag_lines = '0; tag_lines[7] = 1'b1; tag_lines[42] = 1'b1;
    issue(2'd0, 32'h0000_00A5, 32'h0000_00FF, 32'h0, 32'h0, 1, mk(1, 7, 0, 2, 4));
    chk("search_match", match_lines, 64'h9966);
    wait_done();

    // SEARCH_WRITE: write pulse on bits 4..7, one cycle wide.
    tag_lines = '0; tag_lines[3] = 1'b1;
    wl_cycles = 0;
    issue(2'd2, 32'h1, 32'h1, 32'hF0, 32'hF0, 1, mk(1, 3, 0, 1, 5));
    chk("sw_match", match_lines, 64'h2);
    chk("sw_write_before", write_lines, 64'd0);
    wait_done();
    chk("sw_write_after", write_lines, 64'd0);
    chk("sw_write_cycles", 64'(wl_cycles), 64'd1);
    chk("sw_write_value", wl_last, 64'h5500);

    // Search tagging only the last word, then READ reuses its match lines.
    tag_lines = '0; tag_lines[99] = 1'b1;
    issue(2'd0, 32'hF0, 32'hFF, 32'h0, 32'h0, 1, mk(1, 99, 0, 1, 4));
    chk("search99_match", match_lines, 64'hAA55);
    wait_done();
    read_lines = 32'hDEAD_BEEF;
    issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1, mk(1, 99, 32'hDEAD_BEEF, 1, 4));
    wait_done();
    chk("read_match_kept", match_lines, 64'hAA55);

    // No tags, zero search mask, response back-pressured for 5 cycles.
    tag_lines = '0;
    resp_ready = 1'b0;
    issue(2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1, mk(0, 0, 0, 0, 4));
    chk("zero_mask_match", match_lines, 64'd0);
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("bp_resp_seen", 64'(resp_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    resp_ready = 1'b1;
    wait_done();

    // WRITE with zero mask: no write pulse, tags sampled during the write.
    tag_lines = '0; tag_lines[0] = 1'b1; tag_lines[50] = 1'b1;
    wl_cycles = 0;
    issue(2'd1, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1, mk(1, 0, 0, 2, 2));
    wait_done();
    chk("wmask0_write_cycles", 64'(wl_cycles), 64'd0);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/capp_sequencer.md
Name: capp_sequencer

Overview:
- Command-driven controller for the content-addressable cell array (NUM_WORDS words x WORD_W bits).
- Accepts search, write, search-then-write and read commands over a valid/ready handshake.
- Drives the array's dual-rail match and write lines and waits the configured settle and write times.
- Captures the array's per-word tag lines and read lines, then returns a registered response: any-responder flag, first-responder index and read data.

Parameters:
- WORD_W, 32, bits per word; the array has 2*WORD_W match and write lines.
- NUM_WORDS, 100, words in the array; equals the tag line count.
- SETTLE_CYCLES, 2, cycles match lines are held before tags/read lines are sampled; legal range >=1.
- WRITE_CYCLES, 1, cycles write lines are asserted; legal range >=1.
- IDX_W, $clog2(NUM_WORDS), width of the responder index.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=SEARCH, 1=WRITE, 2=SEARCH_WRITE, 3=READ
- cmd_comparand  in  WORD_W  search key
- cmd_smask  in  WORD_W  search mask; 1 = bit participates in the search
- cmd_wdata  in  WORD_W  write data
- cmd_wmask  in  WORD_W  write mask; 1 = bit is written
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_any  out  1  at least one tag line was high at capture
- resp_first_idx  out  IDX_W  lowest index with tag high; 0 if none
- resp_rdata  out  WORD_W  read_lines sampled (READ only, else 0)
- match_lines  out  2*WORD_W  to array
- write_lines  out  2*WORD_W  to array
- tag_lines  in  NUM_WORDS  per-word select lines from array
- read_lines  in  WORD_W  wired-OR read data from array

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - All outputs 0 except cmd_ready=1.
  - Held search registers cleared.
  - Any in-flight operation and pending response are discarded.
  - Deasserting rst_n mid-operation resumes from IDLE with no residual write pulse.
- Match encoding, per bit j, registered:
  - match_lines[2j] = smask[j] & ~comparand[j]
  - match_lines[2j+1] = smask[j] & comparand[j]
  - Loaded only on acceptance of SEARCH or SEARCH_WRITE. Held unchanged otherwise, so WRITE and READ act on the previous search's tags.
- Write encoding, per bit j:
  - write_lines[2j] = wmask[j] & wdata[j]
  - write_lines[2j+1] = wmask[j] & ~wdata[j]
  - Driven only in state WRITE; all zero in every other state.
- States: IDLE, SETTLE, CAPTURE, WRITE, RESP.
  - IDLE: on cmd_valid, latch the command. WRITE goes to WRITE; all others go to SETTLE.
  - SETTLE: counter runs SETTLE_CYCLES cycles, then -> CAPTURE.
  - CAPTURE (1 cycle): register resp_any = OR(tag_lines), the priority-encoded lowest set index, and read_lines (if READ, else 0). SEARCH_WRITE -> WRITE; others -> RESP.
  - WRITE: WRITE_CYCLES cycles, then -> RESP. An op=WRITE response reports tags sampled in the final write cycle.
  - RESP: resp_valid=1, fields stable until resp_ready; on resp_valid & resp_ready -> IDLE.
- Latency from the accept edge to resp_valid high:
  - SEARCH / READ: SETTLE_CYCLES+2
  - SEARCH_WRITE: SETTLE_CYCLES+WRITE_CYCLES+2
  - WRITE: WRITE_CYCLES+1
- Boundary cases:
  - No tags: resp_any=0, resp_first_idx=0.
  - Tag on word NUM_WORDS-1 only: index = NUM_WORDS-1.
  - All masks zero: legal; match/write lines all zero.
  - Single outstanding command; cmd_ready=0 outside IDLE; no back-to-back accept in the RESP->IDLE cycle.

Optional Feature:
- Macro: CAPP_RESP_COUNT_EN.
- When defined:
  - Adds output resp_count, width $clog2(NUM_WORDS+1): population count of tag_lines registered in CAPTURE.
  - resp_count is 0 at reset and held through RESP.
  - The popcount may be pipelined internally. If pipelined, CAPTURE extends to 2 cycles and every latency above grows by 1.
- When undefined: no port, no logic, base latencies apply.

Test Plan:
- Reset mid-SETTLE with rst_n low 3 cycles -> match_lines=0, write_lines=0, resp_valid=0, cmd_ready=1 immediately; the next SEARCH completes normally.
- SEARCH comparand=0x0000_00A5, smask=0x0000_00FF; model tags words 7 and 42 -> match_lines[15:0] bit pattern matches the encoding; resp_valid at accept+4; resp_any=1; resp_first_idx=7; count=2 if enabled.
- SEARCH_WRITE comparand=0x1, smask=0x1, wdata=0xF0, wmask=0xF0 -> write_lines[15:8]=0x55 for exactly WRITE_CYCLES cycles; resp at accept+5; write_lines 0 before and after.
- READ after a search tagging only word 99, with read_lines=0xDEAD_BEEF -> resp_rdata=0xDEAD_BEEF, resp_first_idx=99, match_lines unchanged from the prior search.
- SEARCH with no tags and resp_ready held low 5 cycles -> resp_valid held, resp_any=0, resp_first_idx=0, cmd_ready=0 until the handshake completes.
- WRITE with wmask=0 -> write_lines stay all zero, response after WRITE_CYCLES+1 cycles.
